// File: rtl/bsg_async_ptr_gray_ctrl.sv
// Local pointer side of an async FIFO: binary/gray pointer flops, remote gray synchroniser, full/free tracking.
// Optional almost-full flag enabled by defining BSG_ASYNC_PTR_ALMOST_FULL_EN.
module bsg_async_ptr_gray_ctrl #(
  parameter  int lg_size_p            = 4,
  parameter  int sync_stages_p        = 2,
  parameter  int almost_full_thresh_p = 2,
  localparam int W                    = lg_size_p + 1
) (
  input  logic         clk_i,
  input  logic         reset_n_i,
  input  logic         inc_i,
  output logic [W-1:0] ptr_binary_r_o,
  output logic [W-1:0] ptr_gray_r_o,
  input  logic [W-1:0] r_ptr_gray_i,
  output logic         full_o,
  output logic [W-1:0] free_cnt_o
`ifdef BSG_ASYNC_PTR_ALMOST_FULL_EN
  ,
  output logic         almost_full_o
`endif
);

  localparam logic [W-1:0] DEPTH = {1'b1, {lg_size_p{1'b0}}};

  if (lg_size_p < 1 || sync_stages_p < 2 || almost_full_thresh_p < 0) begin : g_bad_param
    $error("bsg_async_ptr_gray_ctrl: illegal parameter value");
  end

  logic         accept;
  logic [W-1:0] p1_bin_r, p1_gray_r, p2_bin;
  logic [sync_stages_p-1:0][W-1:0] sync_r;
  logic [W-1:0] r_gray_sync, r_bin_sync, diff;

  assign accept = inc_i & ~full_o;
  assign p2_bin = p1_bin_r + W'(1);

  // p1 holds ptr+1 in both encodings so the gray output loads straight from a flop.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ptr_binary_r_o <= '0;
      ptr_gray_r_o   <= '0;
      p1_bin_r       <= W'(1);
      p1_gray_r      <= W'(1);
    end else if (accept) begin
      ptr_binary_r_o <= p1_bin_r;
      ptr_gray_r_o   <= p1_gray_r;
      p1_bin_r       <= p2_bin;
      p1_gray_r      <= p2_bin ^ (p2_bin >> 1);
    end
  end

  // First stage samples the remote gray pointer directly; nothing in front of it.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) sync_r <= '0;
    else            sync_r <= {sync_r[sync_stages_p-2:0], r_ptr_gray_i};
  end

  assign r_gray_sync = sync_r[sync_stages_p-1];

  always_comb begin
    r_bin_sync        = '0;
    r_bin_sync[W-1]   = r_gray_sync[W-1];
    for (int i = W-2; i >= 0; i--)
      r_bin_sync[i] = r_bin_sync[i+1] ^ r_gray_sync[i];
  end

  assign diff       = ptr_binary_r_o - r_bin_sync;
  assign full_o     = (diff == DEPTH);
  assign free_cnt_o = DEPTH - diff;

`ifdef BSG_ASYNC_PTR_ALMOST_FULL_EN
  assign almost_full_o = (free_cnt_o <= W'(almost_full_thresh_p));
`endif

  // A remote pointer ahead of the local one, or more than a FIFO behind, is corrupt.
  a_diff_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i) diff <= DEPTH)
    else $fatal(1, "bsg_async_ptr_gray_ctrl: illegal remote pointer, diff=%0d", diff);

endmodule

// File: tb/tb_bsg_async_ptr_gray_ctrl.sv
// Scoreboard bench for bsg_async_ptr_gray_ctrl (lg_size_p=4, sync_stages_p=2).
module tb_bsg_async_ptr_gray_ctrl;

  logic       clk_i = 1'b0;
  logic       reset_n_i;
  logic       inc_i;
  logic [4:0] ptr_binary_r_o, ptr_gray_r_o, r_ptr_gray_i, free_cnt_o;
  logic       full_o;
`ifdef BSG_ASYNC_PTR_ALMOST_FULL_EN
  logic       almost_full_o;
`endif

  bsg_async_ptr_gray_ctrl #(.lg_size_p(4), .sync_stages_p(2), .almost_full_thresh_p(2)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .inc_i(inc_i),
    .ptr_binary_r_o(ptr_binary_r_o), .ptr_gray_r_o(ptr_gray_r_o),
    .r_ptr_gray_i(r_ptr_gray_i), .full_o(full_o), .free_cnt_o(free_cnt_o)
`ifdef BSG_ASYNC_PTR_ALMOST_FULL_EN
    , .almost_full_o(almost_full_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [4:0] bin;
    logic [4:0] gray;
    logic       full;
    logic [4:0] free;
    logic       af;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // reference state: local pointer count and two-flop view of the remote gray pointer
  int         mb;
  logic [4:0] s0, s1;

  function automatic logic [4:0] g2b(input logic [4:0] g);
    logic [4:0] b;
    b[4] = g[4];
    for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    int   d;
    d      = (mb - int'(g2b(s1))) & 31;
    e.bin  = 5'(mb);
    e.gray = 5'(mb) ^ (5'(mb) >> 1);
    e.free = 5'(16 - d);
    e.full = (d == 16);
    e.af   = ((16 - d) <= 2);
    return e;
  endfunction

  task automatic drive(input logic inc, input logic [4:0] rg);
    exp_t cur;
    cur          = model_out();
    inc_i        = inc;
    r_ptr_gray_i = rg;
    @(posedge clk_i);
    if (inc && !cur.full) mb = (mb + 1) % 32;
    s1 = s0;
    s0 = rg;
    sb.push_back(model_out());
    #1;
    inc_i = 1'b0;
  endtask

  task automatic apply_reset();
    reset_n_i    = 1'b0;
    inc_i        = 1'b0;
    r_ptr_gray_i = '0;
    mb = 0; s0 = '0; s1 = '0;
    sb.delete();
    @(posedge clk_i); #1;
    reset_n_i = 1'b1;
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0; inc_i = 1'b1; r_ptr_gray_i = '0;
    #1;
    n_tests++;
    if (ptr_binary_r_o !== 5'd0 || ptr_gray_r_o !== 5'd0 || full_o !== 1'b0 || free_cnt_o !== 5'd16) begin
      n_fail++;
      $display("FAIL reset_async: bin=%0d gray=%b full=%b free=%0d, want 0 00000 0 16",
               ptr_binary_r_o, ptr_gray_r_o, full_o, free_cnt_o);
    end
    @(posedge clk_i); #1;
    n_tests++;
    if (ptr_binary_r_o !== 5'd0 || ptr_gray_r_o !== 5'd0 || full_o !== 1'b0 || free_cnt_o !== 5'd16) begin
      n_fail++;
      $display("FAIL reset_held: bin=%0d gray=%b full=%b free=%0d, want 0 00000 0 16",
               ptr_binary_r_o, ptr_gray_r_o, full_o, free_cnt_o);
    end
    apply_reset();
  endtask

  task automatic test_fill();
    exp_t e;
    for (int i = 1; i <= 17; i++) begin
      drive(1'b1, 5'd0);
      e = sb.pop_front();
      n_tests++;
      if (ptr_binary_r_o !== e.bin || ptr_gray_r_o !== e.gray || full_o !== e.full || free_cnt_o !== e.free) begin
        n_fail++;
        $display("FAIL fill[%0d]: bin=%0d gray=%b full=%b free=%0d, want %0d %b %b %0d",
                 i, ptr_binary_r_o, ptr_gray_r_o, full_o, free_cnt_o, e.bin, e.gray, e.full, e.free);
      end
      if (i == 16) begin
        n_tests++;
        if (ptr_binary_r_o !== 5'd16 || ptr_gray_r_o !== 5'b11000 || full_o !== 1'b1) begin
          n_fail++;
          $display("FAIL fill_full: bin=%0d gray=%b full=%b, want 16 11000 1",
                   ptr_binary_r_o, ptr_gray_r_o, full_o);
        end
      end
    end
    n_tests++;
    if (ptr_binary_r_o !== 5'd16 || free_cnt_o !== 5'd0) begin
      n_fail++;
      $display("FAIL inc_while_full: bin=%0d free=%0d, want 16 0", ptr_binary_r_o, free_cnt_o);
    end
  endtask

  task automatic test_remote_release();
    exp_t e;
    drive(1'b0, 5'b00001);
    e = sb.pop_front();
    n_tests++;
    if (full_o !== 1'b1 || e.full !== 1'b1) begin
      n_fail++;
      $display("FAIL release_edge1: full=%b, want 1", full_o);
    end
    drive(1'b0, 5'b00001);
    e = sb.pop_front();
    n_tests++;
    if (full_o !== 1'b0 || free_cnt_o !== 5'd1 || full_o !== e.full || free_cnt_o !== e.free) begin
      n_fail++;
      $display("FAIL release_edge2: full=%b free=%0d, want 0 1", full_o, free_cnt_o);
    end
  endtask

  task automatic test_wrap();
    exp_t       e;
    int         hist[40];
    logic [4:0] rg, prev_gray, rb;
    int         bad_toggle;
    apply_reset();
    bad_toggle = 0;
    for (int i = 0; i < 40; i++) begin
      hist[i]   = mb;
      rb        = (i >= 4) ? 5'(hist[i-4]) : 5'd0;
      rg        = rb ^ (rb >> 1);
      prev_gray = ptr_gray_r_o;
      drive(1'b1, rg);
      e = sb.pop_front();
      n_tests++;
      if (ptr_binary_r_o !== e.bin || ptr_gray_r_o !== e.gray || full_o !== e.full || free_cnt_o !== e.free) begin
        n_fail++;
        $display("FAIL wrap[%0d]: bin=%0d gray=%b full=%b free=%0d, want %0d %b %b %0d",
                 i, ptr_binary_r_o, ptr_gray_r_o, full_o, free_cnt_o, e.bin, e.gray, e.full, e.free);
      end
      if ($countones(prev_gray ^ ptr_gray_r_o) != 1) bad_toggle++;
    end
    n_tests++;
    if (bad_toggle != 0 || ptr_binary_r_o !== 5'd8) begin
      n_fail++;
      $display("FAIL wrap_gray_step: bad_steps=%0d bin=%0d, want 0 8", bad_toggle, ptr_binary_r_o);
    end
  endtask

  task automatic test_reset_midstream();
    exp_t e;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5'd0);
      e = sb.pop_front();
      n_tests++;
      if (ptr_binary_r_o !== e.bin || ptr_gray_r_o !== e.gray || free_cnt_o !== e.free) begin
        n_fail++;
        $display("FAIL midstream_run[%0d]: bin=%0d gray=%b free=%0d, want %0d %b %0d",
                 i, ptr_binary_r_o, ptr_gray_r_o, free_cnt_o, e.bin, e.gray, e.free);
      end
    end
    #3;
    reset_n_i = 1'b0;
    r_ptr_gray_i = '0;
    #1;
    n_tests++;
    if (ptr_binary_r_o !== 5'd0 || ptr_gray_r_o !== 5'd0 || full_o !== 1'b0 || free_cnt_o !== 5'd16) begin
      n_fail++;
      $display("FAIL midstream_reset: bin=%0d gray=%b full=%b free=%0d, want 0 00000 0 16",
               ptr_binary_r_o, ptr_gray_r_o, full_o, free_cnt_o);
    end
    apply_reset();
  endtask

`ifdef BSG_ASYNC_PTR_ALMOST_FULL_EN
  task automatic test_almost_full();
    exp_t e;
    apply_reset();
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 5'd0);
      e = sb.pop_front();
      n_tests++;
      if (almost_full_o !== e.af || free_cnt_o !== e.free) begin
        n_fail++;
        $display("FAIL almost_full[%0d]: af=%b free=%0d, want %b %0d", i, almost_full_o, free_cnt_o, e.af, e.free);
      end
      if (i == 13 || i == 14 || i == 16) begin
        n_tests++;
        if (almost_full_o !== (i != 13) || (i == 16 && full_o !== 1'b1)) begin
          n_fail++;
          $display("FAIL almost_full_pt[%0d]: af=%b full=%b", i, almost_full_o, full_o);
        end
      end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fill();
    test_remote_release();
    test_wrap();
    test_reset_midstream();
`ifdef BSG_ASYNC_PTR_ALMOST_FULL_EN
    test_almost_full();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
